// File: rtl/irq_seq_pkg.sv
// irq_seq_pkg: shared state encoding and parameter defaults for the interrupt sequencer
package irq_seq_pkg;
   localparam int          N_IRQ_DEF      = 3;
   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_TAKE = 3'd2,
      S_RET  = 3'd3,
      S_HALT = 3'd4
   } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
//   req : request vector, bit 0 wins
//   idx : index of the lowest set bit (0 when none)
//   vld : at least one request bit set
module irq_prio_enc #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          vld
);
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IW'(i);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/irq_pipe_sequencer.sv
// irq_pipe_sequencer: takes interrupts and ERETs at precise retirement boundaries
//   inputs : clk, rst_n (async, active-high), irq_req/irq_mask, ie, epc,
//            wb_valid/wb_pc_4/wb_eret/wb_halt from the DM/WB register
//   outputs: pipe_en, flush, wb_kill, pc_redirect/pc_target,
//            epc_w_en/epc_w_data, ie_w_en/ie_w_data, irq_ack, in_service
module irq_pipe_sequencer
   import irq_seq_pkg::*;
#(
   parameter int          N_IRQ      = N_IRQ_DEF,
   parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_req,
   input  logic [N_IRQ-1:0] irq_mask,
   input  logic             ie,
   input  logic [31:0]      epc,
   input  logic             wb_valid,
   input  logic [31:0]      wb_pc_4,
   input  logic             wb_eret,
   input  logic             wb_halt,
   output logic             pipe_en,
   output logic             flush,
   output logic             wb_kill,
   output logic             pc_redirect,
   output logic [31:0]      pc_target,
   output logic             epc_w_en,
   output logic [31:0]      epc_w_data,
   output logic             ie_w_en,
   output logic             ie_w_data,
   output logic [N_IRQ-1:0] irq_ack,
   output logic [N_IRQ-1:0] in_service
);
   localparam int               IW  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);
   state_t             state, nxt;
   logic [IW-1:0]      sel, elig_idx, isv_idx;
   logic               elig_vld, isv_vld, catch_ret, can_take, act;
   logic [N_IRQ-1:0]   prio_mask, eligible;
   logic [31:0]        captured_pc;
   // only lines strictly more urgent than the most urgent active handler may preempt
   assign prio_mask = isv_vld ? (ONE << isv_idx) - ONE : '1;
   assign eligible  = irq_req & irq_mask & prio_mask;
   irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_elig_enc (.req(eligible),   .idx(elig_idx), .vld(elig_vld));
   irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_isv_enc  (.req(in_service), .idx(isv_idx),  .vld(isv_vld));
   assign catch_ret = (state == S_IDLE || state == S_ARM) && wb_valid;
   assign can_take  = elig_vld && ie;
   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_IDLE, S_ARM: nxt = catch_ret ? (wb_eret ? S_RET : wb_halt ? S_HALT : can_take ? S_TAKE : S_IDLE)
                                        : (can_take ? S_ARM : S_IDLE);
         S_HALT:        nxt = S_HALT;
         default:       nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= S_IDLE;
         sel         <= '0;
         captured_pc <= '0;
         pc_target   <= '0;
         in_service  <= '0;
      end else begin
         state <= nxt;
         if (nxt == S_RET)
            pc_target <= epc;
         if (nxt == S_TAKE) begin
            sel         <= elig_idx;
            captured_pc <= wb_pc_4;
            pc_target   <= VEC_BASE + 32'(elig_idx) * VEC_STRIDE;
         end
         // clearing the lowest set bit retires the most urgent (innermost) handler
         if (state == S_TAKE)
            in_service <= in_service | (ONE << sel);
         else if (state == S_RET)
            in_service <= in_service & (in_service - ONE);
      end
   end
   assign act         = (state == S_TAKE) || (state == S_RET);
   assign pipe_en     = state != S_HALT;
   assign flush       = act;
   assign wb_kill     = act;
   assign pc_redirect = act;
   assign epc_w_en    = state == S_TAKE;
   assign epc_w_data  = captured_pc;
   assign ie_w_en     = act;
   assign ie_w_data   = state == S_RET;
   assign irq_ack     = (state == S_TAKE) ? (ONE << sel) : '0;
endmodule

// File: tb/tb_irq_pipe_sequencer.sv
// tb_irq_pipe_sequencer: directed scenarios plus randomized traffic against a pending-action model
module tb_irq_pipe_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [2:0]  irq_req = '0, irq_mask = '0;
   logic        ie = 1'b0;
   logic [31:0] epc = '0, wb_pc_4 = '0;
   logic        wb_valid = 1'b0, wb_eret = 1'b0, wb_halt = 1'b0;
   logic        pipe_en, flush, wb_kill, pc_redirect, epc_w_en, ie_w_en, ie_w_data;
   logic [31:0] pc_target, epc_w_data;
   logic [2:0]  irq_ack, in_service;
   int total = 0;
   int bad = 0;

   irq_pipe_sequencer dut (
      .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask), .ie(ie), .epc(epc),
      .wb_valid(wb_valid), .wb_pc_4(wb_pc_4), .wb_eret(wb_eret), .wb_halt(wb_halt),
      .pipe_en(pipe_en), .flush(flush), .wb_kill(wb_kill), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .epc_w_en(epc_w_en), .epc_w_data(epc_w_data), .ie_w_en(ie_w_en),
      .ie_w_data(ie_w_data), .irq_ack(irq_ack), .in_service(in_service)
   );

   always #5 clk = ~clk;

   // model: a pending action (0 none, 1 take, 2 return) executes in the cycle after its retirement
   logic        m_halt = 1'b0;
   int          m_act = 0;
   int          m_sel = 0;
   logic [31:0] m_cpc = '0, m_tgt = '0;
   logic [2:0]  m_isv = '0;

   function automatic int pick_line(input logic [2:0] req, input logic [2:0] msk, input logic [2:0] isv);
      int lo = 3;
      for (int i = 2; i >= 0; i--) if (isv[i]) lo = i;
      for (int i = 0; i < 3; i++) if (req[i] && msk[i] && i < lo) return i;
      return -1;
   endfunction

   function automatic logic [2:0] clear_lowest(input logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) begin
         v[i] = 1'b0;
         return v;
      end
      return v;
   endfunction

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_halt <= 1'b0; m_act <= 0; m_sel <= 0; m_cpc <= '0; m_tgt <= '0; m_isv <= '0;
      end else if (m_halt) begin
         m_act <= 0;
      end else if (m_act == 1) begin
         m_isv <= m_isv | (3'b001 << m_sel);
         m_act <= 0;
      end else if (m_act == 2) begin
         m_isv <= clear_lowest(m_isv);
         m_act <= 0;
      end else if (wb_valid) begin
         if (wb_eret) begin
            m_act <= 2;
            m_tgt <= epc;
         end else if (wb_halt) begin
            m_halt <= 1'b1;
         end else if (ie && pick_line(irq_req, irq_mask, m_isv) >= 0) begin
            m_act <= 1;
            m_sel <= pick_line(irq_req, irq_mask, m_isv);
            m_cpc <= wb_pc_4;
            m_tgt <= 32'h800 + 32'(pick_line(irq_req, irq_mask, m_isv)) * 32'h10;
         end
      end
   end

   logic [76:0] got, expv;
   logic        ma;
   always @(negedge clk) begin
      if (!rst_n) begin
         ma   = m_act != 0;
         got  = {pipe_en, flush, wb_kill, pc_redirect, pc_target, epc_w_en, epc_w_data,
                 ie_w_en, ie_w_data, irq_ack, in_service};
         expv = {!m_halt, ma, ma, ma, m_tgt, m_act == 1, m_cpc, ma, m_act == 2,
                 (m_act == 1) ? (3'b001 << m_sel) : 3'b000, m_isv};
         total++;
         if (got !== expv) begin
            bad++;
            $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, expv);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] pc, input logic er, input logic h);
      wb_valid = v; wb_pc_4 = pc; wb_eret = er; wb_halt = h;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_pipe_en", 32'(pipe_en), 1);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_pc_target", pc_target, 0);
      chk("rst_in_service", 32'(in_service), 0);
      rst_n = 1'b0;
      cyc(0, 0, 0, 0);
      // take on line 1
      ie = 1'b1; irq_mask = 3'b111; irq_req = 3'b010;
      cyc(1, 32'h104, 0, 0);
      chk("t1_epc_w_en", 32'(epc_w_en), 1);
      chk("t1_epc_w_data", epc_w_data, 32'h104);
      chk("t1_pc_target", pc_target, 32'h810);
      chk("t1_irq_ack", 32'(irq_ack), 3'b010);
      chk("t1_ie_w", 32'({ie_w_en, ie_w_data}), 2'b10);
      chk("t1_kill_flush", 32'({wb_kill, flush, pc_redirect}), 3'b111);
      irq_req = 3'b000;
      cyc(0, 0, 0, 0);
      chk("t1_in_service", 32'(in_service), 3'b010);
      chk("t1_flush_after", 32'(flush), 0);
      // preemption by line 0; line 2 alone is blocked
      irq_req = 3'b101;
      cyc(1, 32'h200, 0, 0);
      chk("t2_pc_target", pc_target, 32'h800);
      chk("t2_irq_ack", 32'(irq_ack), 3'b001);
      cyc(0, 0, 0, 0);
      chk("t2_in_service", 32'(in_service), 3'b011);
      irq_req = 3'b100;
      cyc(1, 32'h300, 0, 0);
      chk("t2_line2_blocked", 32'({flush, irq_ack}), 0);
      // return from the line 0 handler
      irq_req = 3'b000; epc = 32'h104;
      cyc(1, 32'h308, 1, 0);
      chk("t3_pc_target", pc_target, 32'h104);
      chk("t3_ie_w", 32'({ie_w_en, ie_w_data}), 2'b11);
      chk("t3_redirect_noack", 32'({pc_redirect, epc_w_en, irq_ack}), 5'b10000);
      cyc(0, 0, 0, 0);
      chk("t3_in_service", 32'(in_service), 3'b010);
      cyc(1, 32'h30c, 1, 0);
      cyc(0, 0, 0, 0);
      chk("t4_isv_clear", 32'(in_service), 0);
      // ERET wins over an eligible request
      irq_req = 3'b100; epc = 32'h500;
      cyc(1, 32'h400, 1, 0);
      chk("t4_ret_target", pc_target, 32'h500);
      chk("t4_ret_noack", 32'({ie_w_data, irq_ack}), 4'b1000);
      cyc(0, 0, 0, 0);
      cyc(1, 32'h504, 0, 0);
      chk("t4_take_ack", 32'(irq_ack), 3'b100);
      chk("t4_take_target", pc_target, 32'h820);
      chk("t4_take_epc", epc_w_data, 32'h504);
      cyc(0, 0, 0, 0);
      chk("t4_in_service", 32'(in_service), 3'b100);
      // request withdrawn during bubbles, then HALT
      irq_req = 3'b000;
      cyc(1, 32'h508, 1, 0);
      cyc(0, 0, 0, 0);
      irq_req = 3'b010;
      repeat (3) cyc(0, 0, 0, 0);
      chk("t5_bubble_no_take", 32'({flush, epc_w_en}), 0);
      irq_req = 3'b000;
      cyc(0, 0, 0, 0);
      cyc(1, 32'h600, 0, 0);
      chk("t5_withdrawn", 32'({flush, epc_w_en, irq_ack}), 0);
      cyc(1, 32'h604, 0, 1);
      chk("t5_halt_pipe_en", 32'(pipe_en), 0);
      irq_req = 3'b111;
      cyc(1, 32'h608, 0, 0);
      cyc(1, 32'h60c, 1, 0);
      chk("t5_halt_ignores", 32'({pipe_en, flush, ie_w_en, irq_ack}), 0);
      // reset in the middle of TAKE
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      rst_n = 1'b0;
      irq_req = 3'b001;
      cyc(0, 0, 0, 0);
      cyc(1, 32'h700, 0, 0);
      chk("t6_in_take", 32'(flush), 1);
      rst_n = 1'b1;
      #1;
      chk("t6_strobes", 32'({flush, wb_kill, pc_redirect, epc_w_en, ie_w_en, irq_ack}), 0);
      chk("t6_pipe_en", 32'(pipe_en), 1);
      chk("t6_in_service", 32'(in_service), 0);
      chk("t6_pc_target", pc_target, 0);
      chk("t6_epc_w_data", epc_w_data, 0);
      cyc(0, 0, 0, 0);
      rst_n = 1'b0;
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst_n    = (k % 400) == 399;
         irq_req  = 3'($urandom);
         irq_mask = 3'($urandom);
         ie       = $urandom_range(0, 3) != 0;
         epc      = $urandom;
         cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
      end
      rst_n = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
